seg7_scan: RTL



---
 rtl/seg7_scan_pkg.sv | 28 ++
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan_bcd_to_seg7.sv | 28 ++
 rtl/seg7_scan.sv | 102 ++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared constants for the clock display path.
//   SEG_*          active-low segment patterns {g,f,e,d,c,b,a}
//   AN_OFF         all six anodes off (active-low)
//   DEF_NUM_DIGITS default digit count (hh:mm:ss)
package seg7_scan_pkg;

  localparam int DEF_NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [5:0] AN_OFF   = 6'b111111;

  // Slots carrying the hh:mm and mm:ss colon dots.
  localparam int COLON_SLOT_LO = 2;
  localparam int COLON_SLOT_HI = 4;

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit data/control in, multiplexed display drive out.
//   D      packed BCD digits, D[4i+3:4i] = digit i
//   EN     display enable
//   COLON  light DP on the colon slots
//   LZB    blank hour-tens digit when it is zero
//   AN     active-low digit enables
//   SEG    active-low segments {g,f,e,d,c,b,a}
//   DP     active-low decimal point
// master = digit source / bench, slave = scanner.
interface seg7_scan_if #(
  parameter int N = 6
);
  logic [4*N-1:0] D;
  logic           EN;
  logic           COLON;
  logic           LZB;
  logic [N-1:0]   AN;
  logic [6:0]     SEG;
  logic           DP;

  modport master (output D, EN, COLON, LZB, input AN, SEG, DP);
  modport slave  (input D, EN, COLON, LZB, output AN, SEG, DP);
endinterface

// File: rtl/seg7_scan_bcd_to_seg7.sv
// bcd_to_seg7: combinational 4-bit BCD to active-low 7-segment decoder.
//   bcd  input digit; codes 10..15 render as a dash
//   seg  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexes NUM_DIGITS BCD digits onto a common-anode
// 7-segment display.
//   CP   system clock, rising edge
//   CR   synchronous active-high reset
//   bus  seg7_scan_if slave: D/EN/COLON/LZB in, AN/SEG/DP out
// Each slot lasts SCAN_DIV cycles, the first BLANK_CYC of them with all
// anodes off to suppress ghosting. Digits are copied into a shadow register
// only at the frame boundary so a whole frame always shows one coherent time.
// SCAN_DIV must be >= 2 and BLANK_CYC < SCAN_DIV.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic         CP,
  input  logic         CR,
  seg7_scan_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_COLON_LO = IDX_W'(COLON_SLOT_LO);
  localparam logic [IDX_W-1:0] IDX_COLON_HI = IDX_W'(COLON_SLOT_HI);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic [3:0]              curDigit;
  logic [6:0]              decSeg;
  logic                    cntWrap;
  logic                    frameEnd;
  logic                    inBlank;
  logic                    lzBlank;
  logic                    anOff;
  logic [NUM_DIGITS-1:0]   anNext;
  logic [6:0]              segNext;
  logic                    dpNext;

  logic [NUM_DIGITS-1:0]   anReg;
  logic [6:0]              segReg;
  logic                    dpReg;

  assign cntWrap  = (cnt == CNT_LAST);
  assign frameEnd = cntWrap && (idx == IDX_LAST);

  // Digit mux written as a loop so idx never indexes past the shadow width.
  always_comb begin
    curDigit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) curDigit = shadow[4*i +: 4];
    end
  end

  bcd_to_seg7 uDecode (
    .bcd (curDigit),
    .seg (decSeg)
  );

  always_comb begin
    inBlank = (cnt < CNT_BLANK);
    lzBlank = bus.LZB && (idx == IDX_LAST) && (curDigit == 4'd0);
    anOff   = inBlank || !bus.EN || lzBlank;
    anNext  = anOff ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << idx);
    segNext = anOff ? SEG_OFF : decSeg;
    dpNext  = !(bus.COLON && !anOff &&
                ((idx == IDX_COLON_LO) || (idx == IDX_COLON_HI)));
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= bus.D;
      anReg  <= {NUM_DIGITS{1'b1}};
      segReg <= SEG_OFF;
      dpReg  <= 1'b1;
    end else begin
      anReg  <= anNext;
      segReg <= segNext;
      dpReg  <= dpNext;
      if (cntWrap) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frameEnd) shadow <= bus.D;
    end
  end

  assign bus.AN  = anReg;
  assign bus.SEG = segReg;
  assign bus.DP  = dpReg;

endmodule
